// File: rtl/icache_nb_mshr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_nb_mshr : non-blocking direct-mapped I-cache with an MSHR file and out-of-order fills.
// Option macro ICACHE_NEXT_LINE_PREFETCH_EN adds next-line prefetch.  Rev 1.0
// ---------------------------------------------------------------------------
module icache_nb_mshr #(
   parameter int NUM_PORTS   = 2,
   parameter int CACHE_LINES = 32,
   parameter int MSHR_DEPTH  = 4,
   parameter int TAG_BITS    = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [TAG_BITS-1:0]        Imem2proc_transaction_tag,
   input  logic [63:0]                Imem2proc_data,
   input  logic [TAG_BITS-1:0]        Imem2proc_data_tag,
   input  logic [NUM_PORTS-1:0][31:0] proc2Icache_addr,
   input  logic [NUM_PORTS-1:0]       valid,
   output logic [1:0]                 proc2Imem_command,
   output logic [31:0]                proc2Imem_addr,
   output logic [NUM_PORTS-1:0][63:0] Icache_data_out,
   output logic [NUM_PORTS-1:0]       Icache_valid_out,
   output logic                       mshr_full
);
   localparam int IDX_W  = $clog2(CACHE_LINES);
   localparam int LTAG_W = 13 - IDX_W;
   localparam int BLK_W  = 29;

   localparam logic [1:0] MEM_NONE = 2'd0;
   localparam logic [1:0] MEM_LOAD = 2'd1;

   localparam logic [1:0] ST_INVALID = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_ISSUED  = 2'd2;

   logic [CACHE_LINES-1:0] line_valid;
   logic [LTAG_W-1:0]      line_tag  [CACHE_LINES];
   logic [63:0]            line_data [CACHE_LINES];

   logic [MSHR_DEPTH-1:0][1:0]          state, state_next;
   logic [MSHR_DEPTH-1:0][BLK_W-1:0]    blk, blk_next;
   logic [MSHR_DEPTH-1:0][TAG_BITS-1:0] mtag, mtag_next;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
   logic [MSHR_DEPTH-1:0]               pf, pf_next, pf_new;
   logic [NUM_PORTS-1:0]                port_alloc;
   logic [BLK_W-1:0]                    pf_blk;
`endif

   logic [NUM_PORTS-1:0][BLK_W-1:0] req_blk;
   logic [NUM_PORTS-1:0]            hit;
   logic [NUM_PORTS*3-1:0]          unused_offset;
   logic [MSHR_DEPTH-1:0]           free_mask, taken, alloc_slot, fill_hit, iss_sel;
   logic [MSHR_DEPTH-1:0][BLK_W-1:0] new_blk;
   logic                            fill_fire, iss_any;
   logic [BLK_W-1:0]                fill_blk, iss_blk;
   logic [IDX_W-1:0]                fill_idx;

   function automatic logic line_hit(input logic [BLK_W-1:0] b);
      line_hit = line_valid[b[IDX_W-1:0]] && (line_tag[b[IDX_W-1:0]] == b[12:IDX_W]);
   endfunction

   // Block already tracked: live entry, allocated earlier this cycle, or being filled now.
   function automatic logic known_block(input logic [BLK_W-1:0] b,
                                        input logic [MSHR_DEPTH-1:0] tk,
                                        input logic [MSHR_DEPTH-1:0][BLK_W-1:0] nb);
      known_block = fill_fire && (fill_blk == b);
      for (int e = 0; e < MSHR_DEPTH; e++) begin
         if ((state[e] != ST_INVALID && blk[e] == b) || (tk[e] && nb[e] == b))
            known_block = 1'b1;
      end
   endfunction

   function automatic logic [MSHR_DEPTH-1:0] pick_free(input logic [MSHR_DEPTH-1:0] avail);
      pick_free = '0;
      for (int e = 0; e < MSHR_DEPTH; e++) begin
         if (avail[e] && pick_free == '0)
            pick_free[e] = 1'b1;
      end
   endfunction

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         req_blk[p]              = proc2Icache_addr[p][31:3];
         hit[p]                  = valid[p] && line_hit(proc2Icache_addr[p][31:3]);
         unused_offset[p*3 +: 3] = proc2Icache_addr[p][2:0];
      end
      for (int e = 0; e < MSHR_DEPTH; e++)
         free_mask[e] = (state[e] == ST_INVALID);
   end

   // Fill matches only entries that were ISSUED before this cycle.
   always_comb begin
      fill_fire = 1'b0;
      fill_hit  = '0;
      fill_blk  = '0;
      for (int e = 0; e < MSHR_DEPTH; e++) begin
         if (!fill_fire && Imem2proc_data_tag != '0 && state[e] == ST_ISSUED &&
             mtag[e] == Imem2proc_data_tag) begin
            fill_fire   = 1'b1;
            fill_hit[e] = 1'b1;
            fill_blk    = blk[e];
         end
      end
   end
   assign fill_idx = fill_blk[IDX_W-1:0];

   always_comb begin
      iss_sel = '0;
      iss_any = 1'b0;
      iss_blk = '0;
      for (int e = 0; e < MSHR_DEPTH; e++) begin
         if (!iss_any && state[e] == ST_PENDING
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
             && !pf[e]
`endif
            ) begin
            iss_any    = 1'b1;
            iss_sel[e] = 1'b1;
            iss_blk    = blk[e];
         end
      end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      for (int e = 0; e < MSHR_DEPTH; e++) begin
         if (!iss_any && state[e] == ST_PENDING) begin
            iss_any    = 1'b1;
            iss_sel[e] = 1'b1;
            iss_blk    = blk[e];
         end
      end
`endif
   end

   always_comb begin
      taken      = '0;
      new_blk    = '0;
      alloc_slot = '0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      pf_new     = '0;
      port_alloc = '0;
      pf_blk     = '0;
`endif
      for (int p = 0; p < NUM_PORTS; p++) begin
         alloc_slot = '0;
         if (valid[p] && !hit[p] && !known_block(req_blk[p], taken, new_blk))
            alloc_slot = pick_free(free_mask & ~taken);
         for (int e = 0; e < MSHR_DEPTH; e++)
            if (alloc_slot[e]) new_blk[e] = req_blk[p];
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
         port_alloc[p] = |alloc_slot;
`endif
         taken = taken | alloc_slot;
      end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      // Next-line prefetches only take what demand allocation left over.
      for (int p = 0; p < NUM_PORTS; p++) begin
         alloc_slot = '0;
         pf_blk     = req_blk[p] + 29'd1;
         if (port_alloc[p] && !line_hit(pf_blk) && !known_block(pf_blk, taken, new_blk))
            alloc_slot = pick_free(free_mask & ~taken);
         for (int e = 0; e < MSHR_DEPTH; e++)
            if (alloc_slot[e]) new_blk[e] = pf_blk;
         taken  = taken | alloc_slot;
         pf_new = pf_new | alloc_slot;
      end
`endif
   end

   always_comb begin
      state_next = state;
      blk_next   = blk;
      mtag_next  = mtag;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      pf_next    = pf;
`endif
      for (int e = 0; e < MSHR_DEPTH; e++) begin
         if (fill_hit[e]) begin
            state_next[e] = ST_INVALID;
         end else if (iss_sel[e] && Imem2proc_transaction_tag != '0) begin
            state_next[e] = ST_ISSUED;
            mtag_next[e]  = Imem2proc_transaction_tag;
         end else if (taken[e]) begin
            state_next[e] = ST_PENDING;
            blk_next[e]   = new_blk[e];
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            pf_next[e]    = pf_new[e];
`endif
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= '0;
         blk        <= '0;
         mtag       <= '0;
         line_valid <= '0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
         pf         <= '0;
`endif
      end else begin
         state <= state_next;
         blk   <= blk_next;
         mtag  <= mtag_next;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
         pf    <= pf_next;
`endif
         if (fill_fire)
            line_valid[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (fill_fire && !reset) begin
         line_data[fill_idx] <= Imem2proc_data;
         line_tag[fill_idx]  <= fill_blk[12:IDX_W];
      end
   end

   always_comb begin
      proc2Imem_command = MEM_NONE;
      proc2Imem_addr    = '0;
      if (iss_any && !reset) begin
         proc2Imem_command = MEM_LOAD;
         proc2Imem_addr    = {iss_blk, 3'b000};
      end
      mshr_full = !reset && (free_mask == '0);
      for (int p = 0; p < NUM_PORTS; p++) begin
         Icache_valid_out[p] = hit[p] && !reset;
         Icache_data_out[p]  = Icache_valid_out[p] ? line_data[req_blk[p][IDX_W-1:0]] : 64'd0;
      end
   end

endmodule
`default_nettype wire
